// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and width definitions for the pipelined ALU.
package alu_pkg;

    localparam int DEF_WIDTH = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_ADC  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_ORR  = 4'd5;
    localparam logic [3:0] OP_EOR  = 4'd6;
    localparam logic [3:0] OP_LSL  = 4'd7;
    localparam logic [3:0] OP_LSR  = 4'd8;
    localparam logic [3:0] OP_ASR  = 4'd9;
    localparam logic [3:0] OP_MOVB = 4'd10;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef logic [3:0] nzcv_t;

    function automatic logic is_arith(input logic [3:0] op);
        return (op <= OP_SBC);
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational execute unit: result and NZCV for one operation.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  nzcv_t            flags_in,
    output logic [WIDTH-1:0] result,
    output nzcv_t            nzcv
);

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] bx;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic             c_msb;

    always_comb begin
        amt = b[SHW-1:0];
        bx  = (op == OP_SUB || op == OP_SBC) ? ~b : b;

        unique case (op)
            OP_SUB:         cin = 1'b1;
            OP_ADC, OP_SBC: cin = flags_in[F_C];
            default:        cin = 1'b0;
        endcase

        sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
        // Carry into the MSB recovered from the MSB sum bit.
        c_msb = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];

        result = '0;
        unique case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: result = sum[WIDTH-1:0];
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            OP_EOR:  result = a ^ b;
            OP_LSL:  result = a << amt;
            OP_LSR:  result = a >> amt;
            OP_ASR:  result = WIDTH'($signed(a) >>> amt);
            OP_MOVB: result = b;
            default: result = '0;
        endcase

        nzcv      = flags_in;
        nzcv[F_N] = result[WIDTH-1];
        nzcv[F_Z] = (result == '0);
        if (is_arith(op)) begin
            nzcv[F_C] = sum[WIDTH];
            nzcv[F_V] = c_msb ^ sum[WIDTH];
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage ALU pipeline: operand register (A), result register (B),
// architectural NZCV flag register, valid/ready on both sides.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_set_flag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags
);

    logic             a_valid;
    logic [WIDTH-1:0] a_a;
    logic [WIDTH-1:0] a_b;
    logic [3:0]       a_op;
    logic             a_set;

    logic             b_valid;
    logic [WIDTH-1:0] b_result;
    nzcv_t            b_nzcv;
    nzcv_t            flag_reg;

    logic             accept;
    logic             a_adv;
    logic [WIDTH-1:0] ex_result;
    nzcv_t            ex_nzcv;

    assign in_ready = !reset & (!a_valid | !b_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign a_adv    = a_valid & (!b_valid | out_ready);

    alu_exec #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_exec (
        .a        (a_a),
        .b        (a_b),
        .op       (a_op),
        .flags_in (flag_reg),
        .result   (ex_result),
        .nzcv     (ex_nzcv)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_a     <= '0;
            a_b     <= '0;
            a_op    <= '0;
            a_set   <= 1'b0;
        end else if (accept) begin
            a_valid <= 1'b1;
            a_a     <= in_a;
            a_b     <= in_b;
            a_op    <= in_op;
            a_set   <= in_set_flag;
        end else if (a_adv) begin
            a_valid <= 1'b0;
        end
    end

    // Result data is held after draining so outputs never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            b_valid  <= 1'b0;
            b_result <= '0;
            b_nzcv   <= '0;
        end else if (a_adv) begin
            b_valid  <= 1'b1;
            b_result <= ex_result;
            b_nzcv   <= ex_nzcv;
        end else if (out_ready) begin
            b_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_reg <= '0;
        end else if (a_adv && a_set) begin
            flag_reg <= ex_nzcv;
        end
    end

    assign out_valid  = b_valid;
    assign out_result = b_result;
    assign out_nzcv   = b_nzcv;
    assign flags      = flag_reg;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed self-checking bench for pipelined_alu (WIDTH=64).
module tb_pipelined_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [3:0]  in_op;
    logic        in_set_flag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_nzcv;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_alu #(.WIDTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .in_set_flag (in_set_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_nzcv    (out_nzcv),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic sf);
        in_valid    = 1'b1;
        in_op       = op;
        in_a        = a;
        in_b        = b;
        in_set_flag = sf;
    endtask

    int sent;
    int recv;
    logic [63:0] held;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_op = '0;
        in_set_flag = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_nzcv", 64'(out_nzcv), 64'd0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);

        // ADD overflow into sign bit
        drive(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_result", out_result, 64'h8000_0000_0000_0000);
        chk("add_nzcv", 64'(out_nzcv), 64'b1001);
        chk("add_flags", 64'(flags), 64'b1001);

        // SUB then ADC consuming the fresh carry
        drive(4'd1, 64'd5, 64'd5, 1'b1);
        cyc();
        drive(4'd2, 64'd0, 64'd0, 1'b0);
        cyc();
        chk("sub_result", out_result, 64'd0);
        chk("sub_nzcv", 64'(out_nzcv), 64'b0110);
        chk("sub_flags", 64'(flags), 64'b0110);
        in_valid = 1'b0;
        cyc();
        chk("adc_valid", 64'(out_valid), 64'd1);
        chk("adc_result", out_result, 64'd1);
        chk("adc_nzcv", 64'(out_nzcv), 64'b0000);
        chk("adc_flags_kept", 64'(flags), 64'b0110);

        // Shifts; C and V carried from flags (C=1)
        drive(4'd7, 64'd1, 64'hFFFF_FFFF_FFFF_FF41, 1'b0);
        cyc();
        drive(4'd9, 64'h8000_0000_0000_0000, 64'd63, 1'b0);
        cyc();
        chk("lsl_result", out_result, 64'd2);
        chk("lsl_nzcv", 64'(out_nzcv), 64'b0010);
        drive(4'd8, 64'h0000_0000_0000_ABCD, 64'h40, 1'b0);
        cyc();
        chk("asr_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("asr_nzcv", 64'(out_nzcv), 64'b1010);
        in_valid = 1'b0;
        cyc();
        chk("lsr0_result", out_result, 64'h0000_0000_0000_ABCD);
        chk("lsr0_nzcv", 64'(out_nzcv), 64'b0010);

        // Reserved op with flags=0010
        drive(4'd1, 64'd5, 64'd3, 1'b1);
        cyc();
        drive(4'd12, 64'd77, 64'd99, 1'b0);
        cyc();
        chk("sub2_result", out_result, 64'd2);
        chk("sub2_flags", 64'(flags), 64'b0010);
        in_valid = 1'b0;
        cyc();
        chk("rsv_result", out_result, 64'd0);
        chk("rsv_nzcv", 64'(out_nzcv), 64'b0110);
        cyc();
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // Stream of 8 with a 5-cycle stall
        sent = 0;
        recv = 0;
        held = '0;
        for (int t = 0; t < 40 && recv < 8; t++) begin
            out_ready = !(t >= 2 && t < 7);
            if (sent < 8) begin
                if (sent % 2 == 0) drive(4'd0, 64'(sent), 64'd100, 1'b0);
                else drive(4'd10, 64'd5, 64'(100 + sent), 1'b0);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t == 3) begin
                held = out_result;
                chk("stall_in_ready", 64'(in_ready), 64'd0);
            end
            if (t == 6) begin
                chk("stall_in_ready_late", 64'(in_ready), 64'd0);
                chk("stall_result_stable", out_result, held);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("stream_%0d", recv), out_result,
                    64'(100 + recv));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", 64'(sent), 64'd8);
        chk("stream_recv", 64'(recv), 64'd8);
        cyc();
        chk("stream_no_dup", 64'(out_valid), 64'd0);

        // Reset with two ops in flight
        drive(4'd1, 64'd5, 64'd3, 1'b1);
        out_ready = 1'b0;
        cyc();
        drive(4'd0, 64'd2, 64'd2, 1'b1);
        cyc();
        in_valid = 1'b0;
        chk("inflight_flags", 64'(flags), 64'b0010);
        chk("inflight_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        cyc();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_flags", 64'(flags), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_result", out_result, 64'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        drive(4'd0, 64'd2, 64'd3, 1'b0);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_result", out_result, 64'd5);
        cyc();
        chk("post_rst_drained", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
